// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : shared constants for the up/down/load counter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;
  localparam int          c_default_width = 8;
  localparam int unsigned c_reset_value   = 0;
endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_next.sv
// ============================================================================
// counter_next : combinational next-count logic (load > count > hold)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] datain,
  input  logic             load,
  input  logic             counten,
  input  logic             inc,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  // Modular add/subtract gives the silent wrap at both ends.
  always_comb begin
    nxt = cur;
    if (load) begin
      nxt = datain;
    end else if (counten) begin
      nxt = inc ? (cur + c_one) : (cur - c_one);
    end
  end

endmodule : counter_next

`default_nettype wire

// File: rtl/counter.sv
// ============================================================================
// counter : WIDTH-bit up/down counter with parallel load and sync clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] datain,
  input  logic             inc,
  input  logic             load,
  input  logic             counten
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_nxt;

  counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .cur     (r_count),
    .datain  (datain),
    .load    (load),
    .counten (counten),
    .inc     (inc),
    .nxt     (w_nxt)
  );

  // Clear has top priority and sits outside the next-state block.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= WIDTH'(c_reset_value);
    end else begin
      r_count <= w_nxt;
    end
  end

  assign out = r_count;

endmodule : counter

`default_nettype wire

// File: tb/tb_counter.sv
// ============================================================================
// tb_counter : directed + random scoreboard bench for counter (WIDTH 8 and 4)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, load, counten, inc;
  logic [7:0] datain, out;
  logic       clear4, load4, counten4, inc4;
  logic [3:0] datain4, out4;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q8[$];
  logic [3:0] q4[$];
  logic [3:0] m4;

  counter #(.WIDTH(8)) dut (
    .clk(clk), .clear(clear), .out(out), .datain(datain),
    .inc(inc), .load(load), .counten(counten)
  );

  counter #(.WIDTH(4)) dut4 (
    .clk(clk), .clear(clear4), .out(out4), .datain(datain4),
    .inc(inc4), .load(load4), .counten(counten4)
  );

  // Apply one edge on the 8-bit counter with its expected result queued.
  task automatic step8(input string tag, input logic c, input logic l,
                       input logic ce, input logic up, input logic [7:0] d,
                       input logic [7:0] exp);
    logic [7:0] e;
    clear = c; load = l; counten = ce; inc = up; datain = d;
    q8.push_back(exp);
    @(posedge clk);
    #1;
    e = q8.pop_front();
    vectors++;
    assert (out === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, out, e);
    end
  endtask

  // Reference model for the 4-bit instance.
  function automatic logic [3:0] model4(input logic [3:0] cur, input logic c,
                                        input logic l, input logic ce,
                                        input logic up, input logic [3:0] d);
    if (c)       return 4'h0;
    else if (l)  return d;
    else if (ce) return up ? cur + 4'h1 : cur - 4'h1;
    else         return cur;
  endfunction

  task automatic step4(input string tag, input logic c, input logic l,
                       input logic ce, input logic up, input logic [3:0] d);
    logic [3:0] e;
    clear4 = c; load4 = l; counten4 = ce; inc4 = up; datain4 = d;
    m4 = model4(m4, c, l, ce, up, d);
    q4.push_back(m4);
    @(posedge clk);
    #1;
    e = q4.pop_front();
    vectors++;
    assert (out4 === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, out4, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    clear = 1'b1; load = 1'b0; counten = 1'b1; inc = 1'b1; datain = 8'h00;
    clear4 = 1'b1; load4 = 1'b0; counten4 = 1'b0; inc4 = 1'b1; datain4 = 4'h0;
    m4 = 4'h0;
    #1;

    for (int i = 0; i < 5; i++) step8("reset", 1, 0, 1, 1, 8'hA5, 8'h00);

    step8("load_prio", 0, 1, 1, 1, 8'h6C, 8'h6C);
    step8("up1",       0, 0, 1, 1, 8'h00, 8'h6D);
    step8("up2",       0, 0, 1, 1, 8'h00, 8'h6E);
    step8("down1",     0, 0, 1, 0, 8'h00, 8'h6D);
    step8("down2",     0, 0, 1, 0, 8'h00, 8'h6C);

    step8("load_ff",   0, 1, 0, 0, 8'hFF, 8'hFF);
    step8("wrap_up",   0, 0, 1, 1, 8'h00, 8'h00);
    step8("wrap_down", 0, 0, 1, 0, 8'h00, 8'hFF);

    step8("load_42",   0, 1, 1, 0, 8'h42, 8'h42);
    step8("hold1",     0, 0, 0, 1, 8'h13, 8'h42);
    step8("hold2",     0, 0, 0, 0, 8'h99, 8'h42);
    step8("hold3",     0, 0, 0, 1, 8'h00, 8'h42);
    step8("clr_load",  1, 1, 1, 1, 8'h55, 8'h00);
    step8("resume_up", 0, 0, 1, 1, 8'h00, 8'h01);
    step8("resume_ld", 0, 1, 0, 1, 8'h80, 8'h80);
    step8("clr_count", 1, 0, 1, 0, 8'h00, 8'h00);
    step8("under",     0, 0, 1, 0, 8'h00, 8'hFF);

    // 4-bit instance: directed wrap, then random traffic against the model.
    step4("w4_clear",  1, 0, 0, 1, 4'h0);
    step4("w4_load_f", 0, 1, 0, 1, 4'hF);
    step4("w4_wrap",   0, 0, 1, 1, 4'h0);
    for (int i = 0; i < 60; i++) begin
      step4("w4_rand",
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_counter

`default_nettype wire
